// File: rtl/key_expansion_seq.sv
// key_expansion_seq
//   Iterative AES key expansion (128/192/256-bit keys). After an accepted
//   start, one 32-bit schedule word is produced per clock. The schedule is
//   presented flattened for the inverse cipher: round key r occupies
//   key_out[128*(r+1)-1 -: 128], and word w[4r] is its most significant word.
//
// Ports
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, clears all state and outputs
//   start   : load key and begin expansion (honoured in IDLE and DONE only)
//   size    : 00 AES-128, 01 AES-192, 10 AES-256, 11 treated as 00
//   key     : cipher key, left-aligned (w[0] = key[255:224])
//   key_out : flattened round-key schedule, unused round keys read zero
//   nr      : round count of the latched key size (0 after reset)
//   busy    : expansion in progress
//   valid   : key_out holds a complete schedule
module key_expansion_seq #(
   parameter int NR_MAX = 14
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                size,
   input  logic [255:0]              key,
   output logic [128*(NR_MAX+1)-1:0] key_out,
   output logic [3:0]                nr,
   output logic                      busy,
   output logic                      valid
);

   localparam int NW = 4 * (NR_MAX + 1);

   // Forward AES S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t      state_reg, state_next;
   logic [31:0] w_reg [NW];
   logic [5:0]  i_reg;
   logic [2:0]  p_reg;
   logic [3:0]  nk_reg;
   logic [3:0]  nr_reg;
   logic [7:0]  rcon_reg;
   logic        busy_reg;
   logic        valid_reg;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = 11'd2047 - {b, 3'b000};
      return SBOX[idx -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic        accept;
   logic [1:0]  size_eff;
   logic [3:0]  nk_new;
   logic [3:0]  nr_new;
   logic [5:0]  last_idx;
   logic [31:0] prev_word;
   logic [31:0] back_word;
   logic [31:0] temp;
   logic [31:0] new_word;

   always_comb begin
      accept    = start && (state_reg != EXPAND);
      size_eff  = (size == 2'b11) ? 2'b00 : size;
      nk_new    = 4'd4 + {1'b0, size_eff, 1'b0};
      nr_new    = nk_new + 4'd6;
      last_idx  = {nr_reg, 2'b00} + 6'd3;
      prev_word = w_reg[i_reg - 6'd1];
      back_word = w_reg[i_reg - {2'b00, nk_reg}];
      temp      = prev_word;
      if (p_reg == 3'd0) begin
         temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_reg, 24'h000000};
      end else if (nk_reg == 4'd8 && p_reg == 3'd4) begin
         temp = sub_word(prev_word);
      end
      new_word = back_word ^ temp;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = EXPAND;
         EXPAND:  if (i_reg == last_idx) state_next = DONE;
         DONE:    if (start) state_next = EXPAND;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NW; j++) w_reg[j] <= 32'h0;
         i_reg     <= 6'd0;
         p_reg     <= 3'd0;
         nk_reg    <= 4'd0;
         nr_reg    <= 4'd0;
         rcon_reg  <= 8'h00;
         busy_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         busy_reg  <= (state_next == EXPAND);
         valid_reg <= (state_next == DONE);
         if (accept) begin
            nk_reg   <= nk_new;
            nr_reg   <= nr_new;
            i_reg    <= {2'b00, nk_new};
            p_reg    <= 3'd0;
            rcon_reg <= 8'h01;
            // Whole schedule is cleared so round keys beyond Nr read zero;
            // the key words written afterwards override the clear.
            for (int j = 0; j < NW; j++) w_reg[j] <= 32'h0;
            for (int j = 0; j < 8; j++) begin
               if (4'(j) < nk_new) w_reg[j] <= key[255-32*j -: 32];
            end
         end else if (state_reg == EXPAND) begin
            w_reg[i_reg] <= new_word;
            i_reg        <= i_reg + 6'd1;
            // p tracks i mod Nk without a divider.
            p_reg        <= (({1'b0, p_reg} + 4'd1) == nk_reg) ? 3'd0 : p_reg + 3'd1;
            if (p_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NW; gi++) begin : g_key_out
         assign key_out[128*(gi/4) + 32*(3-(gi%4)) +: 32] = w_reg[gi];
      end
   endgenerate

   assign nr    = nr_reg;
   assign busy  = busy_reg;
   assign valid = valid_reg;

endmodule
